w_mem_read_sequencer: RTL and testbench

- Controller that sequences one weight memory (1-cycle registered read, ports wen/ren/wadd/radd/win/wout) for one neuron of the FNN accelerator.
- Walks read addresses 0..numWeight-1 in lockstep with an incoming activation stream.
- Pairs each activation with its weight and drives the neuron MAC with clear, valid and last.
- Arbitrates weight-load writes into the same memory, allowing them only while the neuron is idle.

---
 rtl/fnn_pkg.sv | 13 +
 rtl/w_mem_read_sequencer.sv | 130 +++++++++++++
 tb/tb_w_mem_read_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnn_pkg.sv
// Shared types and constants for the FNN accelerator neuron datapath.
package fnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int DATA_WIDTH = 16;

endpackage

// File: rtl/w_mem_read_sequencer.sv
// Weight-memory read sequencer for one neuron: walks weight addresses in
// lockstep with the activation stream, aligns each activation with its
// 1-cycle-late weight for the MAC, and lets weight-load writes in only
// while the neuron is idle.
module w_mem_read_sequencer
    import fnn_pkg::*;
#(
    parameter int numWeight    = 10,
    // A single-weight neuron still needs a 1-bit address bus.
    parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
    parameter int dataWidth    = DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [dataWidth-1:0]    x_in,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    output logic                    mac_clr,
    output logic                    mac_valid,
    output logic [dataWidth-1:0]    mac_x,
    output logic [dataWidth-1:0]    mac_w,
    output logic                    mac_last,
    input  logic                    cfg_wen,
    input  logic [addressWidth-1:0] cfg_wadd,
    input  logic [dataWidth-1:0]    cfg_win,
    output logic                    cfg_ack,
    output logic                    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win
);

    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    seq_state_t              state, state_nxt;
    logic [addressWidth-1:0] cnt, cnt_nxt;
    logic                    fire;
    logic                    clr_nxt;
    logic [dataWidth-1:0]    x_d1;
    logic                    v_d1;
    logic                    last_d1;

    // Next-state, handshake, read-address and write-gate decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_ready   = 1'b0;
        fire      = 1'b0;
        ren       = 1'b0;
        radd      = '0;
        clr_nxt   = 1'b0;
        wen       = 1'b0;
        wadd      = '0;
        win       = '0;
        case (state)
            IDLE: begin
                // A pending write beats start; the requester re-issues start.
                if (cfg_wen) begin
                    wen  = 1'b1;
                    wadd = cfg_wadd;
                    win  = cfg_win;
                end else if (start) begin
                    clr_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                x_ready = 1'b1;
                fire    = x_valid;
                if (fire) begin
                    ren  = 1'b1;
                    radd = cnt;
                    if (cnt == LAST_IDX) state_nxt = DRAIN;
                    else                 cnt_nxt   = cnt + addressWidth'(1);
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Memory write port must be quiet while reset is held.
        if (rst) begin
            wen  = 1'b0;
            wadd = '0;
            win  = '0;
        end
    end

    // State, counter, MAC clear pulse and write acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mac_clr <= 1'b0;
            cfg_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mac_clr <= clr_nxt;
            cfg_ack <= wen;
        end
    end

    // Delay the activation one cycle so it lines up with the registered read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_d1    <= '0;
            v_d1    <= 1'b0;
            last_d1 <= 1'b0;
        end else begin
            v_d1    <= fire;
            last_d1 <= fire && (cnt == LAST_IDX);
            if (fire) x_d1 <= x_in;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mac_valid = v_d1;
    assign mac_x     = x_d1;
    assign mac_w     = wout;
    assign mac_last  = last_d1 && v_d1;

endmodule

// File: tb/tb_w_mem_read_sequencer.sv
// Bench: sequencer plus a behavioural 1-cycle-read weight memory, checked
// against a shadow weight table and per-run pair lists.
module tb_w_mem_read_sequencer;

    localparam int N  = 10;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, busy, done;
    logic          x_valid, x_ready;
    logic [DW-1:0] x_in;
    logic          ren;
    logic [AW-1:0] radd;
    logic [DW-1:0] wout;
    logic          mac_clr, mac_valid, mac_last;
    logic [DW-1:0] mac_x, mac_w;
    logic          cfg_wen, cfg_ack, wen;
    logic [AW-1:0] cfg_wadd, wadd;
    logic [DW-1:0] cfg_win, win;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] mem    [N];
    logic [DW-1:0] shadow [N];

    w_mem_read_sequencer #(.numWeight(N), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
        .ren(ren), .radd(radd), .wout(wout),
        .mac_clr(mac_clr), .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w),
        .mac_last(mac_last),
        .cfg_wen(cfg_wen), .cfg_wadd(cfg_wadd), .cfg_win(cfg_win), .cfg_ack(cfg_ack),
        .wen(wen), .wadd(wadd), .win(win)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory with registered read.
    always @(posedge clk) begin
        if (wen && wadd < AW'(N)) mem[wadd] <= win;
        if (ren && radd < AW'(N)) wout <= mem[radd];
    end

    task automatic test_reset();
        checks++;
        if ({busy, done, x_ready, ren, radd, mac_clr, mac_valid, mac_x, mac_last,
             cfg_ack, wen, wadd, win} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b xr=%b ren=%b radd=%0h clr=%b mv=%b mx=%0h ml=%b ack=%b wen=%b wadd=%0h win=%0h, want all 0",
                     busy, done, x_ready, ren, radd, mac_clr, mac_valid, mac_x, mac_last,
                     cfg_ack, wen, wadd, win);
        end
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cfg_wen = 1'b1; cfg_wadd = a; cfg_win = d;
        #1;
        checks++;
        if (wen !== 1'b1 || wadd !== a || win !== d) begin
            errors++;
            $display("FAIL cfg_write_port got wen=%b wadd=%0h win=%0h want 1/%0h/%0h", wen, wadd, win, a, d);
        end
        @(negedge clk);
        checks++;
        if (cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write_ack got %b want 1", cfg_ack);
        end
        cfg_wen = 1'b0;
        shadow[a] = d;
    endtask

    task automatic test_load();
        for (int i = 0; i < N; i++) cfg_write(AW'(i), DW'(i + 1));
    endtask

    // One full evaluation. mode: 0 = x_valid held, 1 = toggling, 2 = random.
    // spam keeps start high while busy; wr holds a write to index 3 over the run.
    task automatic run_eval(input string name, input int mode, input bit spam, input bit wr);
        logic [DW-1:0] xs [N];
        int            fire_cyc [$];
        int            val_cyc  [$];
        logic [DW-1:0] ox [$];
        logic [DW-1:0] ow [$];
        logic          ol [$];
        int            sent = 0, clr_cnt = 0, clr_cyc = -1, done_cnt = 0, done_cyc = -1;
        bit            fin = 0;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b0; cfg_wen = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(negedge clk);
            if (mac_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (mac_valid) begin
                val_cyc.push_back(cyc); ox.push_back(mac_x); ow.push_back(mac_w); ol.push_back(mac_last);
            end
            if (done) begin done_cnt++; done_cyc = cyc; fin = 1; end
            start = spam && !done;
            if (sent < N) begin
                case (mode)
                    0:       x_valid = 1'b1;
                    1:       x_valid = (t % 2 == 0);
                    default: x_valid = 1'($urandom_range(0, 1));
                endcase
                x_in = (mode == 2) ? DW'($urandom) : DW'(16'h10 + sent);
            end else begin
                x_valid = 1'b0;
            end
            if (wr && t == 0) begin cfg_wen = 1'b1; cfg_wadd = 4'd3; cfg_win = 16'hABCD; end
            #1;
            if (x_valid && x_ready) begin
                checks++;
                if (ren !== 1'b1 || radd !== sent[AW-1:0]) begin
                    errors++;
                    $display("FAIL %s read_addr got ren=%b radd=%0d want 1/%0d", name, ren, radd, sent);
                end
                xs[sent] = x_in; fire_cyc.push_back(cyc); sent++;
            end else begin
                checks++;
                if (ren !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ren_idle got %b want 0", name, ren);
                end
            end
            if (sent == N && !x_valid) begin
                checks++;
                if (x_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s x_ready_after_last got %b want 0", name, x_ready);
                end
            end
            if (wr && busy) begin
                checks++;
                if (wen !== 1'b0 || cfg_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL %s write_held got wen=%b ack=%b want 0/0", name, wen, cfg_ack);
                end
            end
        end
        x_valid = 1'b0; start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout got done never want done within 200 cycles", name);
        end
        checks++;
        if (clr_cnt !== 1) begin
            errors++;
            $display("FAIL %s mac_clr_count got %0d want 1", name, clr_cnt);
        end
        checks++;
        if (ox.size() != N || fire_cyc.size() != N) begin
            errors++;
            $display("FAIL %s pair_count got %0d pairs %0d fires want %0d", name, ox.size(), fire_cyc.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (ox[k] !== xs[k] || ow[k] !== shadow[k] || ol[k] !== (k == N - 1) ||
                    val_cyc[k] !== fire_cyc[k] + 1) begin
                    errors++;
                    $display("FAIL %s pair%0d got x=%0h w=%0h last=%b lat=%0d want x=%0h w=%0h last=%b lat=1",
                             name, k, ox[k], ow[k], ol[k], val_cyc[k] - fire_cyc[k], xs[k], shadow[k], (k == N - 1));
                end
            end
            checks++;
            if (!(clr_cyc < val_cyc[0])) begin
                errors++;
                $display("FAIL %s clr_before_valid got clr@%0d valid@%0d want clr earlier", name, clr_cyc, val_cyc[0]);
            end
            checks++;
            if (done_cnt !== 1 || done_cyc !== fire_cyc[N-1] + 2) begin
                errors++;
                $display("FAIL %s done_timing got cnt=%0d at +%0d want 1 at +2", name, done_cnt, done_cyc - fire_cyc[N-1]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_drop got busy=%b done=%b want 0/0", name, busy, done);
        end
        if (wr) begin
            checks++;
            if (wen !== 1'b1 || wadd !== 4'd3 || win !== 16'hABCD) begin
                errors++;
                $display("FAIL %s write_granted got wen=%b wadd=%0h win=%0h want 1/3/abcd", name, wen, wadd, win);
            end
            @(negedge clk);
            checks++;
            if (cfg_ack !== 1'b1) begin
                errors++;
                $display("FAIL %s write_ack got %b want 1", name, cfg_ack);
            end
            cfg_wen = 1'b0;
            shadow[3] = 16'hABCD;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mac_clr !== 1'b0) begin
            errors++;
            $display("FAIL %s stay_idle got busy=%b clr=%b want 0/0", name, busy, mac_clr);
        end
    endtask

    task automatic test_start_wen_together();
        @(negedge clk);
        start = 1'b1; cfg_wen = 1'b1; cfg_wadd = 4'd7; cfg_win = 16'h1234;
        #1;
        checks++;
        if (wen !== 1'b1 || wadd !== 4'd7 || win !== 16'h1234) begin
            errors++;
            $display("FAIL collide_write got wen=%b wadd=%0h win=%0h want 1/7/1234", wen, wadd, win);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mac_clr !== 1'b0 || cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL collide_state got busy=%b clr=%b ack=%b want 0/0/1", busy, mac_clr, cfg_ack);
        end
        start = 1'b0; cfg_wen = 1'b0;
        shadow[7] = 16'h1234;
        run_eval("after_collide", 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        int fires = 0;
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 50 && fires < 5; t++) begin
            @(negedge clk);
            start = 1'b0; x_valid = 1'b1; x_in = DW'(16'h10 + fires);
            #1;
            if (x_ready) fires++;
        end
        @(negedge clk);
        rst = 1'b1; cfg_wen = 1'b1; cfg_wadd = 4'd2; cfg_win = 16'h5555;
        #1;
        checks++;
        if ({busy, done, x_ready, ren, radd, mac_clr, mac_valid, mac_x, mac_last,
             cfg_ack, wen, wadd, win} !== '0) begin
            errors++;
            $display("FAIL midrun_reset busy=%b done=%b xr=%b ren=%b radd=%0h clr=%b mv=%b mx=%0h ml=%b ack=%b wen=%b, want all 0",
                     busy, done, x_ready, ren, radd, mac_clr, mac_valid, mac_x, mac_last, cfg_ack, wen);
        end
        @(negedge clk);
        rst = 1'b0; x_valid = 1'b0; cfg_wen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_no_done got done=%b busy=%b want 0/0", done, busy);
            end
        end
        run_eval("after_reset", 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) cfg_write(AW'($urandom_range(0, N - 1)), DW'($urandom));
            run_eval("random", 2, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_in = '0;
        cfg_wen = 1'b0; cfg_wadd = '0; cfg_win = '0;
        #3;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_load();
        run_eval("basic", 0, 0, 0);
        run_eval("gapped", 1, 0, 0);
        run_eval("wr_arb", 0, 0, 1);
        run_eval("wr_readback", 0, 0, 0);
        test_start_wen_together();
        test_reset_mid_run();
        run_eval("start_ignored", 0, 1, 0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
